// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the sequential MixColumns unit.
package aes_pkg;

  typedef enum logic [1:0] {
    CIPH_FWD = 2'b01,
    CIPH_INV = 2'b10
  } ciph_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mix_cols_seq_state_e;

  typedef logic [3:0][3:0][7:0] aes_state_t;  // [row][col]
  typedef logic [3:0][7:0]      aes_col_t;    // [row]

  // xtime: multiply by x modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] aes_mul2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] aes_mul4(input logic [7:0] a);
    return aes_mul2(aes_mul2(a));
  endfunction

endpackage

// File: rtl/aes_mix_single_column.sv
// One-column MixColumns / InvMixColumns, purely combinational.
module aes_mix_single_column
  import aes_pkg::*;
(
  input  ciph_op_e op_i,
  input  aes_col_t data_i,
  output aes_col_t data_o
);

  logic     inv;
  logic [7:0] u, v;
  aes_col_t pre;

  assign inv = (op_i == CIPH_INV);
  assign u   = aes_mul4(data_i[0] ^ data_i[2]);
  assign v   = aes_mul4(data_i[1] ^ data_i[3]);

  // InvMixColumns = MixColumns applied after a cheap {5,0,4,0} pre-mix,
  // so both directions share the forward xtime network.
  for (genvar i = 0; i < 4; i++) begin : g_row
    assign pre[i]    = data_i[i] ^ (inv ? ((i % 2 == 0) ? u : v) : 8'h00);
    assign data_o[i] = aes_mul2(pre[i] ^ pre[(i+1)%4]) ^ pre[(i+1)%4]
                     ^ pre[(i+2)%4] ^ pre[(i+3)%4];
  end

endmodule

// File: rtl/aes_mix_columns_seq.sv
// Iterative MixColumns/InvMixColumns over the full state, ColsPerCycle columns per clock.
module aes_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int ColsPerCycle = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  ciph_op_e              op_i,
  input  logic [3:0][3:0][7:0]  state_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [3:0][3:0][7:0]  state_o,
  output logic                  err_o,
  output logic                  busy_o
);

  if (!(ColsPerCycle == 1 || ColsPerCycle == 2 || ColsPerCycle == 4)) begin : g_bad_cfg
    $error("aes_mix_columns_seq: ColsPerCycle must be 1, 2 or 4");
  end

  localparam int         NumIter = 4 / ColsPerCycle;
  localparam logic [1:0] LastCol = 2'((NumIter - 1) * ColsPerCycle);

  mix_cols_seq_state_e fsm_q, fsm_d;
  aes_state_t          st_q, st_d;
  logic [1:0]          col_q, col_d;
  ciph_op_e            op_q, op_d;
  logic                err_q, err_d;
  logic                vld_q, vld_d;
  logic                accept;

  aes_col_t [ColsPerCycle-1:0]   col_in, col_out;
  logic [ColsPerCycle-1:0][1:0]  col_idx;

  for (genvar g = 0; g < ColsPerCycle; g++) begin : g_col
    assign col_idx[g] = col_q + 2'(g);
    for (genvar r = 0; r < 4; r++) begin : g_sel
      assign col_in[g][r] = st_q[r][col_idx[g]];
    end
    aes_mix_single_column u_col (
      .op_i   (op_q),
      .data_i (col_in[g]),
      .data_o (col_out[g])
    );
  end

  assign in_ready_o = !clear_i && (fsm_q == IDLE || (fsm_q == DONE && out_ready_i));
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    fsm_d = fsm_q;
    st_d  = st_q;
    col_d = col_q;
    op_d  = op_q;
    err_d = err_q;
    vld_d = vld_q;
    if (clear_i) begin
      fsm_d = IDLE;
      st_d  = '0;
      col_d = '0;
      op_d  = ciph_op_e'(2'b00);
      err_d = 1'b0;
      vld_d = 1'b0;
    end else if (accept) begin
      fsm_d = BUSY;
      col_d = '0;
      op_d  = op_i;
      vld_d = 1'b0;
      if (op_i == CIPH_FWD || op_i == CIPH_INV) begin
        st_d  = state_i;
        err_d = 1'b0;
      end else begin
        st_d  = '0;
        err_d = 1'b1;
      end
    end else begin
      case (fsm_q)
        BUSY: begin
          // An illegal op spends a single cycle here with no column work.
          if (err_q) begin
            fsm_d = DONE;
            vld_d = 1'b1;
          end else begin
            for (int g = 0; g < ColsPerCycle; g++) begin
              for (int r = 0; r < 4; r++) begin
                st_d[r][col_idx[g]] = col_out[g][r];
              end
            end
            col_d = col_q + 2'(ColsPerCycle);
            if (col_q == LastCol) begin
              fsm_d = DONE;
              vld_d = 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready_i) begin
            fsm_d = IDLE;
            vld_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm_q <= IDLE;
      st_q  <= '0;
      col_q <= '0;
      op_q  <= ciph_op_e'(2'b00);
      err_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      st_q  <= st_d;
      col_q <= col_d;
      op_q  <= op_d;
      err_q <= err_d;
      vld_q <= vld_d;
    end
  end

  assign state_o     = st_q;
  assign err_o       = err_q;
  assign out_valid_o = vld_q;
  assign busy_o      = (fsm_q != IDLE);

endmodule

// File: tb/tb_aes_mix_columns_seq.sv
// Bench for aes_mix_columns_seq: three instances (1, 2, 4 columns/cycle) against a GF matrix model.
module tb_aes_mix_columns_seq;
  import aes_pkg::*;

  typedef logic [3:0][3:0][7:0] state_t;

  logic gclk = 1'b0;
  logic rst;
  always #5 gclk = ~gclk;

  logic     in_valid [3];
  ciph_op_e op       [3];
  state_t   st_in    [3];
  logic     out_ready[3];
  logic     clear    [3];
  logic     in_ready [3];
  logic     out_valid[3];
  logic     err      [3];
  logic     busy     [3];
  state_t   st_out   [3];

  int errors = 0;
  int checks = 0;

  function automatic int cpc_of(int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_mix_columns_seq #(.ColsPerCycle((g == 0) ? 1 : (g == 1) ? 2 : 4)) u_dut (
      .clk_i       (gclk),
      .rst_i       (rst),
      .clear_i     (clear[g]),
      .in_valid_i  (in_valid[g]),
      .in_ready_o  (in_ready[g]),
      .op_i        (op[g]),
      .state_i     (st_in[g]),
      .out_valid_o (out_valid[g]),
      .out_ready_i (out_ready[g]),
      .state_o     (st_out[g]),
      .err_o       (err[g]),
      .busy_o      (busy[g])
    );
  end

  // ---------------- reference model ----------------
  // Carry-less product reduced modulo 0x11B.
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic state_t mix(state_t s, logic inv);
    logic [7:0] cf [4];
    logic [7:0] acc;
    state_t o;
    if (inv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(cf[(j - r + 4) % 4], s[j][c]);
        o[r][c] = acc;
      end
    return o;
  endfunction

  // Column word is written row0 first: 32'hdb135345 => row0=db .. row3=45.
  function automatic state_t fill4(logic [31:0] w0, logic [31:0] w1, logic [31:0] w2, logic [31:0] w3);
    state_t s;
    logic [31:0] w [4];
    w = '{w0, w1, w2, w3};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = w[c][31-8*r -: 8];
    return s;
  endfunction

  function automatic state_t fill(logic [31:0] w);
    return fill4(w, w, w, w);
  endfunction

  int     cyc = 0;
  logic   pend    [3] = '{1'b0, 1'b0, 1'b0};
  int     due     [3] = '{0, 0, 0};
  state_t exp_st  [3];
  logic   exp_err [3] = '{1'b0, 1'b0, 1'b0};

  always @(posedge gclk) cyc <= cyc + 1;

  function automatic logic exp_rdy(int k);
    return !clear[k] && (!pend[k] || (cyc >= due[k] && out_ready[k]));
  endfunction

  always @(posedge gclk or posedge rst) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) pend[k] <= 1'b0;
      else if (clear[k]) pend[k] <= 1'b0;
      else if (in_valid[k] && exp_rdy(k)) begin
        pend[k] <= 1'b1;
        if (op[k] == CIPH_FWD || op[k] == CIPH_INV) begin
          exp_st[k]  <= mix(st_in[k], op[k] == CIPH_INV);
          exp_err[k] <= 1'b0;
          due[k]     <= cyc + 1 + 4 / cpc_of(k);
        end else begin
          exp_st[k]  <= '0;
          exp_err[k] <= 1'b1;
          due[k]     <= cyc + 2;
        end
      end else if (pend[k] && cyc >= due[k] && out_ready[k]) pend[k] <= 1'b0;
    end
  end

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge gclk) begin
    for (int k = 0; k < 3; k++) begin
      check($sformatf("in_ready[%0d]@%0d", k, cyc), 128'(in_ready[k]), 128'(exp_rdy(k)));
      check($sformatf("busy[%0d]@%0d", k, cyc), 128'(busy[k]), 128'(pend[k]));
      check($sformatf("out_valid[%0d]@%0d", k, cyc), 128'(out_valid[k]),
            128'(pend[k] && cyc >= due[k]));
      if (pend[k] && cyc >= due[k]) begin
        check($sformatf("state_o[%0d]@%0d", k, cyc), st_out[k], exp_st[k]);
        check($sformatf("err_o[%0d]@%0d", k, cyc), 128'(err[k]), 128'(exp_err[k]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge gclk);
    #1;
  endtask

  task automatic send(int k, ciph_op_e o, state_t s);
    in_valid[k] = 1'b1;
    op[k]       = o;
    st_in[k]    = s;
    tick();
    in_valid[k] = 1'b0;
    op[k]       = CIPH_INV;
    st_in[k]    = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic wait_valid(int k, output int n);
    n = 0;
    while (!out_valid[k] && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic check_reset_outputs(string tag, int k);
    check({tag, "_in_ready"}, 128'(in_ready[k]), 128'(1'b1));
    check({tag, "_out_valid"}, 128'(out_valid[k]), 128'(1'b0));
    check({tag, "_busy"}, 128'(busy[k]), 128'(1'b0));
    check({tag, "_err"}, 128'(err[k]), 128'(1'b0));
    check({tag, "_state"}, st_out[k], 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    state_t hold;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; op[k] = CIPH_FWD; st_in[k] = '0;
      out_ready[k] = 1'b1; clear[k] = 1'b0;
    end
    tick(); tick();
    for (int k = 0; k < 3; k++) check_reset_outputs($sformatf("reset%0d", k), k);
    rst = 1'b0;
    tick();

    // FWD, one column per cycle
    send(0, CIPH_FWD, fill(32'hdb135345));
    wait_valid(0, n);
    check("fwd1_latency", 128'(n), 128'(4));
    check("fwd1_state", st_out[0], fill(32'h8e4da1bc));
    tick();

    // INV, full state per cycle
    send(2, CIPH_INV, fill(32'h8e4da1bc));
    wait_valid(2, n);
    check("inv4_latency", 128'(n), 128'(1));
    check("inv4_state", st_out[2], fill(32'hdb135345));
    tick();

    // FWD, two columns per cycle, mixed column vectors
    send(1, CIPH_FWD, fill4(32'hf20a225c, 32'hc6c6c6c6, 32'h01010101, 32'hd4d4d4d5));
    wait_valid(1, n);
    check("fwd2_latency", 128'(n), 128'(2));
    check("fwd2_state", st_out[1], fill4(32'h9fdc589d, 32'hc6c6c6c6, 32'h01010101, 32'hd5d5d7d6));
    tick();

    // Backpressure, then same-edge output and input handshakes
    out_ready[1] = 1'b0;
    send(1, CIPH_INV, fill4(32'h9fdc589d, 32'hc6c6c6c6, 32'h01010101, 32'hd5d5d7d6));
    wait_valid(1, n);
    check("bp_inv_state", st_out[1], fill4(32'hf20a225c, 32'hc6c6c6c6, 32'h01010101, 32'hd4d4d4d5));
    hold = st_out[1];
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_state", st_out[1], hold);
      check("bp_hold_in_ready", 128'(in_ready[1]), 128'(1'b0));
    end
    out_ready[1] = 1'b1;
    #1;
    check("bp_release_in_ready", 128'(in_ready[1]), 128'(1'b1));
    send(1, CIPH_FWD, fill(32'hdb135345));
    wait_valid(1, n);
    check("bp_next_latency", 128'(n), 128'(2));
    check("bp_next_state", st_out[1], fill(32'h8e4da1bc));
    tick();

    // Illegal ops, then a legal op clears the error
    send(0, ciph_op_e'(2'b11), fill(32'h12345678));
    wait_valid(0, n);
    check("illegal_latency", 128'(n), 128'(1));
    check("illegal_err", 128'(err[0]), 128'(1'b1));
    check("illegal_state", st_out[0], 128'(0));
    tick();
    send(2, ciph_op_e'(2'b00), fill(32'hcafef00d));
    wait_valid(2, n);
    check("illegal00_err", 128'(err[2]), 128'(1'b1));
    tick();
    send(0, CIPH_FWD, fill(32'h01010101));
    wait_valid(0, n);
    check("legal_after_err", 128'(err[0]), 128'(1'b0));
    tick();

    // Clear during the second BUSY cycle
    send(0, CIPH_FWD, fill(32'hdb135345));
    tick();
    clear[0] = 1'b1;
    tick();
    clear[0] = 1'b0;
    check("clear_busy", 128'(busy[0]), 128'(1'b0));
    check("clear_state", st_out[0], 128'(0));
    clear[0] = 1'b1;
    in_valid[0] = 1'b1;
    #1;
    check("clear_blocks_ready", 128'(in_ready[0]), 128'(1'b0));
    tick();
    clear[0] = 1'b0;
    in_valid[0] = 1'b0;
    check("clear_no_accept", 128'(busy[0]), 128'(1'b0));
    for (int i = 0; i < 6; i++) begin
      tick();
      check("clear_no_valid", 128'(out_valid[0]), 128'(1'b0));
    end

    // Asynchronous reset mid-BUSY, then accept on the first edge after release
    send(0, CIPH_FWD, fill(32'hdb135345));
    tick();
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid", 0);
    tick();
    rst = 1'b0;
    send(0, CIPH_FWD, fill(32'hf20a225c));
    wait_valid(0, n);
    check("post_rst_latency", 128'(n), 128'(4));
    check("post_rst_state", st_out[0], fill(32'h9fdc589d));
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
